// File: rtl/lamp_pkg.sv
// Shared types and constants for the lamp keyframe pipeline.
// Bank roles start as from=2, to=0, wr=1 and only ever rotate.
package lamp_pkg;

    localparam int unsigned c_bank_w      = 2;
    localparam int unsigned c_frac_w_dflt = 8;

    typedef logic [c_bank_w-1:0] bank_t;

    localparam bank_t c_from_rst = 2'd2;
    localparam bank_t c_to_rst   = 2'd0;
    localparam bank_t c_wr_rst   = 2'd1;

    typedef enum logic [1:0] {
        W_FREE,
        W_LOADING,
        W_FULL
    } wr_state_t;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } run_state_t;

endpackage

// File: rtl/frac_divider.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first.
// Loads on i_start, pulses o_done with the final quotient; i_abort drops the job.
module frac_divider #(
    parameter int unsigned c_num_w = 18,
    parameter int unsigned c_den_w = 10,
    parameter int unsigned c_q_w   = 9
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [c_num_w-1:0] i_num,
    input  logic [c_den_w-1:0] i_den,
    output logic               o_done,
    output logic [c_q_w-1:0]   o_quot
);

    localparam int unsigned        c_cnt_w    = $clog2(c_num_w + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_num_w - 1);

    logic               busy;
    logic [c_cnt_w-1:0] cnt;
    logic [c_num_w-1:0] num_sh;
    logic [c_den_w-1:0] den;
    logic [c_den_w-1:0] rem;
    logic [c_den_w-1:0] rem_nx;
    logic [c_den_w:0]   trial;
    logic               q_bit;

    // remainder stays below den, so the non-subtracted trial fits c_den_w bits
    always_comb begin
        trial  = {rem, num_sh[c_num_w-1]};
        q_bit  = (trial >= {1'b0, den});
        rem_nx = q_bit ? c_den_w'(trial - {1'b0, den}) : trial[c_den_w-1:0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            num_sh <= '0;
            den    <= '0;
            rem    <= '0;
            o_quot <= '0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_abort) begin
                busy <= 1'b0;
            end else if (i_start) begin
                busy   <= 1'b1;
                cnt    <= '0;
                num_sh <= i_num;
                den    <= i_den;
                rem    <= '0;
                o_quot <= '0;
            end else if (busy) begin
                rem    <= rem_nx;
                num_sh <= num_sh << 1;
                o_quot <= {o_quot[c_q_w-2:0], q_bit};
                cnt    <= cnt + c_cnt_w'(1);
                if (cnt == c_cnt_last) begin
                    busy   <= 1'b0;
                    o_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/keyframe_scheduler.sv
// Keyframe transition sequencer over a triple-buffered framebuffer:
// rotates bank roles, times transitions in ticks and produces the blend fraction.
module keyframe_scheduler
    import lamp_pkg::*;
#(
    parameter int unsigned c_max_time = 1024,
    parameter int unsigned c_max_type = 64,
    parameter int unsigned c_frac_w   = c_frac_w_dflt,
    parameter int unsigned c_tick_div = 48000,
    parameter int unsigned c_time_w   = $clog2(c_max_time),
    parameter int unsigned c_type_w   = $clog2(c_max_type)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_kf_start,
    input  logic                i_kf_done,
    input  logic [c_time_w-1:0] i_kf_time,
    input  logic [c_type_w-1:0] i_kf_type,
    output logic [1:0]          o_wr_bank,
    output logic                o_wr_ready,
    output logic [1:0]          o_from_bank,
    output logic [1:0]          o_to_bank,
    output logic [c_type_w-1:0] o_type,
    output logic [c_frac_w:0]   o_progress,
    output logic                o_busy,
    output logic                o_tick,
    output logic                o_drop
);

    localparam int unsigned          c_presc_w   = $clog2(c_tick_div);
    localparam logic [c_presc_w-1:0] c_presc_end = c_presc_w'(c_tick_div - 1);
    localparam logic [c_frac_w:0]    c_prog_full = {1'b1, {c_frac_w{1'b0}}};

    wr_state_t           wr_state, wr_state_nx;
    run_state_t          run_state, run_state_nx;
    logic [c_presc_w-1:0] presc;
    logic                tick_w;
    logic [c_time_w-1:0] dur, dur_nx;
    logic [c_time_w-1:0] elapsed, elapsed_nx, elapsed_inc;
    logic [c_time_w-1:0] pend_time, pend_time_nx, l_time;
    logic [c_type_w-1:0] pend_type, pend_type_nx, l_type;
    logic [c_type_w-1:0] type_nx;
    logic [1:0]          from_nx, to_nx, wr_nx;
    logic [c_frac_w:0]   progress_nx;
    logic                busy_nx, wr_ready_nx, drop_nx;
    logic                done_ld, launch;
    logic                div_start, div_abort, div_done;
    logic [c_frac_w:0]   div_quot;

    assign tick_w      = (presc == c_presc_end);
    assign elapsed_inc = elapsed + c_time_w'(1);
    assign done_ld     = (wr_state == W_LOADING) && i_kf_done;

    frac_divider #(
        .c_num_w (c_time_w + c_frac_w),
        .c_den_w (c_time_w),
        .c_q_w   (c_frac_w + 1)
    ) u_div (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (div_start),
        .i_abort (div_abort),
        .i_num   ({elapsed_inc, {c_frac_w{1'b0}}}),
        .i_den   (dur),
        .o_done  (div_done),
        .o_quot  (div_quot)
    );

    always_comb begin
        wr_state_nx  = wr_state;
        run_state_nx = run_state;
        from_nx      = o_from_bank;
        to_nx        = o_to_bank;
        wr_nx        = o_wr_bank;
        type_nx      = o_type;
        dur_nx       = dur;
        elapsed_nx   = elapsed;
        pend_time_nx = pend_time;
        pend_type_nx = pend_type;
        progress_nx  = o_progress;
        div_start    = 1'b0;
        div_abort    = 1'b0;
        launch       = 1'b0;
        l_time       = i_kf_time;
        l_type       = i_kf_type;
        drop_nx      = (wr_state == W_FULL) && i_kf_start && !i_kf_done;

        if (div_done) progress_nx = div_quot;

        // completion and launch share one edge; a done arriving now counts as pending
        if (run_state == S_RUN && tick_w) begin
            elapsed_nx = elapsed_inc;
            if (elapsed_inc == dur) begin
                progress_nx  = c_prog_full;
                run_state_nx = S_IDLE;
                div_abort    = 1'b1;
                if (wr_state == W_FULL) begin
                    launch = 1'b1;
                    l_time = pend_time;
                    l_type = pend_type;
                end else if (done_ld) begin
                    launch = 1'b1;
                end
            end else begin
                div_start = 1'b1;
            end
        end else if (run_state == S_IDLE && done_ld) begin
            launch = 1'b1;
        end

        if (launch) begin
            from_nx     = o_to_bank;
            to_nx       = o_wr_bank;
            wr_nx       = o_from_bank;
            type_nx     = l_type;
            dur_nx      = l_time;
            elapsed_nx  = '0;
            div_abort   = 1'b1;
            wr_state_nx = W_FREE;
            if (l_time == '0) begin
                progress_nx  = c_prog_full;
                run_state_nx = S_IDLE;
            end else begin
                progress_nx  = '0;
                run_state_nx = S_RUN;
            end
        end else if (done_ld) begin
            wr_state_nx  = W_FULL;
            pend_time_nx = i_kf_time;
            pend_type_nx = i_kf_type;
        end else if (i_kf_start && !i_kf_done && wr_state == W_FREE) begin
            wr_state_nx = W_LOADING;
        end

        busy_nx     = (run_state_nx == S_RUN);
        wr_ready_nx = (wr_state_nx != W_FULL);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_state    <= W_FREE;
            run_state   <= S_IDLE;
            presc       <= '0;
            o_tick      <= 1'b0;
            o_from_bank <= c_from_rst;
            o_to_bank   <= c_to_rst;
            o_wr_bank   <= c_wr_rst;
            o_type      <= '0;
            o_progress  <= c_prog_full;
            o_busy      <= 1'b0;
            o_wr_ready  <= 1'b1;
            o_drop      <= 1'b0;
            dur         <= '0;
            elapsed     <= '0;
            pend_time   <= '0;
            pend_type   <= '0;
        end else begin
            presc       <= tick_w ? '0 : presc + c_presc_w'(1);
            o_tick      <= tick_w;
            wr_state    <= wr_state_nx;
            run_state   <= run_state_nx;
            o_from_bank <= from_nx;
            o_to_bank   <= to_nx;
            o_wr_bank   <= wr_nx;
            o_type      <= type_nx;
            o_progress  <= progress_nx;
            o_busy      <= busy_nx;
            o_wr_ready  <= wr_ready_nx;
            o_drop      <= drop_nx;
            dur         <= dur_nx;
            elapsed     <= elapsed_nx;
            pend_time   <= pend_time_nx;
            pend_type   <= pend_type_nx;
        end
    end

endmodule

// File: tb/tb_keyframe_scheduler.sv
// Self-checking bench for keyframe_scheduler: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_keyframe_scheduler;

    localparam int DIV  = 32;
    localparam int TW   = 10;
    localparam int YW   = 6;
    localparam int FULL = 256;
    localparam int LAT  = 19;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          kf_start = 1'b0;
    logic          kf_done = 1'b0;
    logic [TW-1:0] kf_time = '0;
    logic [YW-1:0] kf_type = '0;
    logic [1:0]    o_wr_bank, o_from_bank, o_to_bank;
    logic          o_wr_ready, o_busy, o_tick, o_drop;
    logic [YW-1:0] o_type;
    logic [8:0]    o_progress;

    int errors = 0;
    int checks = 0;

    keyframe_scheduler #(.c_tick_div(DIV)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_kf_start  (kf_start),
        .i_kf_done   (kf_done),
        .i_kf_time   (kf_time),
        .i_kf_type   (kf_type),
        .o_wr_bank   (o_wr_bank),
        .o_wr_ready  (o_wr_ready),
        .o_from_bank (o_from_bank),
        .o_to_bank   (o_to_bank),
        .o_type      (o_type),
        .o_progress  (o_progress),
        .o_busy      (o_busy),
        .o_tick      (o_tick),
        .o_drop      (o_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 bank free, 1 decoder loading, 2 keyframe waiting
    int m_n = 0, m_cyc = 0, m_mode = 0, m_dur = 0, m_el = 0;
    int m_pt = 0, m_pty = 0, m_due = -1, m_dv = 0;
    int m_from = 2, m_to = 0, m_wr = 1, m_type = 0, m_prog = FULL;
    int m_busy = 0, m_tick = 0, m_drop = 0;

    task automatic m_reset();
        m_n = 0; m_mode = 0; m_dur = 0; m_el = 0; m_due = -1;
        m_from = 2; m_to = 0; m_wr = 1; m_type = 0; m_prog = FULL;
        m_busy = 0; m_tick = 0; m_drop = 0;
    endtask

    task automatic m_launch(input int dd, input int ty);
        int tmp;
        tmp = m_from; m_from = m_to; m_to = m_wr; m_wr = tmp;
        m_type = ty; m_dur = dd; m_el = 0; m_due = -1; m_mode = 0;
        if (dd == 0) begin m_prog = FULL; m_busy = 0; end
        else begin m_prog = 0; m_busy = 1; end
    endtask

    task automatic m_step();
        int tk, dl, wasb, lau;
        m_cyc++;
        tk = (m_n == DIV - 1);
        m_n = (m_n + 1) % DIV;
        m_tick = tk;
        m_drop = (m_mode == 2 && kf_start && !kf_done);
        dl = (m_mode == 1 && kf_done);
        if (m_due == m_cyc) begin m_prog = m_dv; m_due = -1; end
        wasb = m_busy;
        lau = 0;
        if (wasb && tk) begin
            m_el++;
            if (m_el == m_dur) begin
                m_prog = FULL; m_due = -1; m_busy = 0;
                if (m_mode == 2) begin m_launch(m_pt, m_pty); lau = 1; end
                else if (dl) begin m_launch(int'(kf_time), int'(kf_type)); lau = 1; end
            end else begin
                m_due = m_cyc + LAT;
                m_dv = (m_el * FULL) / m_dur;
            end
        end else if (!wasb && dl) begin
            m_launch(int'(kf_time), int'(kf_type));
            lau = 1;
        end
        if (!lau) begin
            if (dl) begin m_mode = 2; m_pt = int'(kf_time); m_pty = int'(kf_type); end
            else if (kf_start && !kf_done && m_mode == 0) m_mode = 1;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else m_step();
    end

    always @(negedge clk) begin
        chk("from_bank", o_from_bank, m_from);
        chk("to_bank", o_to_bank, m_to);
        chk("wr_bank", o_wr_bank, m_wr);
        chk("type", o_type, m_type);
        chk("progress", o_progress, m_prog);
        chk("busy", o_busy, m_busy);
        chk("tick", o_tick, m_tick);
        chk("drop", o_drop, m_drop);
        chk("wr_ready", o_wr_ready, (m_mode != 2));
    end

    // ---------------- directed helpers ----------------
    task automatic wait_tick();
        int k = 0;
        do begin @(negedge clk); k++; end while (!o_tick && k < 64);
        chk("tick_seen", o_tick, 1);
    endtask

    task automatic drive_kf(input int tm, input int ty);
        @(negedge clk); kf_start = 1'b1;
        @(negedge clk); kf_start = 1'b0; kf_done = 1'b1;
        kf_time = TW'(tm); kf_type = YW'(ty);
        @(negedge clk); kf_done = 1'b0;
    endtask

    task automatic measure(input int exp_val);
        int k = 0;
        logic [8:0] prev;
        wait_tick();
        prev = o_progress;
        do begin @(negedge clk); k++; end while (o_progress == prev && k < 40);
        chk("div_latency", k, LAT);
        chk("div_value", o_progress, exp_val);
    endtask

    task automatic chk_banks(input int f, input int t, input int w);
        chk("lit_from", o_from_bank, f);
        chk("lit_to", o_to_bank, t);
        chk("lit_wr", o_wr_bank, w);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state and tick period
        chk_banks(2, 0, 1);
        chk("lit_rst_prog", o_progress, 256);
        chk("lit_rst_busy", o_busy, 0);
        chk("lit_rst_wrrdy", o_wr_ready, 1);
        wait_tick();
        k = 0;
        do begin @(negedge clk); k++; end while (!o_tick && k < 64);
        chk("tick_period", k, 32);

        // basic transition, duration 4
        drive_kf(4, 5);
        chk_banks(0, 1, 2);
        chk("lit_type", o_type, 5);
        chk("lit_prog0", o_progress, 0);
        chk("lit_busy1", o_busy, 1);
        measure(64);
        measure(128);
        measure(192);
        wait_tick();
        chk("lit_end_prog", o_progress, 256);
        chk("lit_end_busy", o_busy, 0);

        // duration 3, then hard cut
        drive_kf(3, 9);
        chk_banks(1, 2, 0);
        measure(85);
        measure(170);
        wait_tick();
        chk("lit_end3", o_progress, 256);
        drive_kf(0, 2);
        chk_banks(2, 0, 1);
        chk("lit_cut_prog", o_progress, 256);
        chk("lit_cut_busy", o_busy, 0);

        // pending keyframe, drop, back-to-back launch
        drive_kf(4, 1);
        chk_banks(0, 1, 2);
        wait_tick();
        drive_kf(2, 7);
        chk("lit_pend_wrrdy", o_wr_ready, 0);
        @(negedge clk); kf_start = 1'b1;
        @(negedge clk); kf_start = 1'b0;
        chk("lit_drop", o_drop, 1);
        @(negedge clk);
        chk("lit_drop_end", o_drop, 0);
        wait_tick();
        wait_tick();
        wait_tick();
        chk_banks(1, 2, 0);
        chk("lit_chain_prog", o_progress, 0);
        chk("lit_chain_type", o_type, 7);
        chk("lit_chain_busy", o_busy, 1);
        chk("lit_chain_wrrdy", o_wr_ready, 1);
        measure(128);
        wait_tick();
        chk("lit_chain_end", o_progress, 256);

        // restart and simultaneous start/done
        @(negedge clk); kf_start = 1'b1;
        @(negedge clk);
        @(negedge clk); kf_start = 1'b0; kf_done = 1'b1; kf_time = TW'(1); kf_type = YW'(3);
        @(negedge clk); kf_done = 1'b0;
        chk_banks(2, 0, 1);
        chk("lit_restart_busy", o_busy, 1);
        wait_tick();
        chk("lit_restart_end", o_progress, 256);
        @(negedge clk); kf_start = 1'b1;
        @(negedge clk); kf_done = 1'b1; kf_time = TW'(0); kf_type = YW'(4);
        @(negedge clk); kf_start = 1'b0; kf_done = 1'b0;
        chk_banks(0, 1, 2);
        chk("lit_sim_drop", o_drop, 0);
        @(negedge clk);
        chk("lit_sim_drop2", o_drop, 0);

        // async reset mid-divide
        drive_kf(3, 6);
        wait_tick();
        repeat (5) @(negedge clk);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk_banks(2, 0, 1);
        chk("lit_arst_prog", o_progress, 256);
        chk("lit_arst_busy", o_busy, 0);
        chk("lit_arst_type", o_type, 0);
        chk("lit_arst_wrrdy", o_wr_ready, 1);
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (40) @(negedge clk);

        // randomized traffic
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (rst) rst = 1'b0;
            kf_start = ($urandom_range(0, 9) == 0);
            kf_done  = ($urandom_range(0, 7) == 0);
            kf_time  = TW'($urandom_range(0, 5));
            kf_type  = YW'($urandom_range(0, 63));
            if ($urandom_range(0, 1499) == 0) begin
                #3 rst = 1'b1;
            end
        end
        @(negedge clk);
        rst = 1'b0; kf_start = 1'b0; kf_done = 1'b0;
        repeat (200) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
